// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: ALU ops, opcode/funct
// fields, datapath mux selects and trap causes.
package riscv_pkg;

  localparam int unsigned ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_OR  = 3'd2,
    ALU_AND = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    SRC_A_PC     = 2'd0,
    SRC_A_OLD_PC = 2'd1,
    SRC_A_RS1    = 2'd2
  } src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_FOUR = 2'd1,
    SRC_B_IMM  = 2'd2
  } src_b_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_sel_e;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_PC     = 2'd2,
    WB_IMM    = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    TRAP_NONE        = 2'b00,
    TRAP_ILLEGAL     = 2'b01,
    TRAP_MEM_TIMEOUT = 2'b10
  } trap_cause_e;

endpackage

// File: rtl/riscv_alu_decode.sv
// Maps opcode/funct3/funct7 to an ALU operation and flags encodings the core
// does not implement.
module riscv_alu_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_e    alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        case (funct3)
          F3_ADD: begin
            if (funct7 == F7_ALT)       alu_op = ALU_SUB;
            else if (funct7 != F7_BASE) illegal = 1'b1;
          end
          F3_AND: begin alu_op = ALU_AND; illegal = (funct7 != F7_BASE); end
          F3_OR:  begin alu_op = ALU_OR;  illegal = (funct7 != F7_BASE); end
          F3_SLT: begin alu_op = ALU_SLT; illegal = (funct7 != F7_BASE); end
          default: illegal = 1'b1;
        endcase
      end
      // funct7 is immediate data for I-type, so only funct3 matters
      OPC_OP_IMM: begin
        case (funct3)
          F3_ADD:  alu_op = ALU_ADD;
          F3_AND:  alu_op = ALU_AND;
          F3_OR:   alu_op = ALU_OR;
          F3_SLT:  alu_op = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE: illegal = (funct3 != F3_W);
      OPC_BRANCH: begin
        alu_op  = ALU_SUB;
        illegal = !((funct3 == F3_BEQ) || (funct3 == F3_BNE));
      end
      OPC_JAL, OPC_LUI: illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I control FSM: sequences the shared datapath, handshakes the
// unified memory port and traps on illegal encodings or memory timeout.
module riscv_mc_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 3,
  parameter int unsigned MAX_WAIT   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_addr_sel,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic                  pc_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [2:0]            imm_sel,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  reg_we,
  output logic [1:0]            wb_sel,
  output logic                  retire,
  output logic                  halted,
  output logic [1:0]            trap_cause
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JAL, S_LUI, S_TRAP
  } state_e;

  state_e            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [1:0]        cause_q, cause_nxt;
  alu_op_e           alu_op, dec_op;
  logic              dec_illegal;
  logic              wait_expired;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  riscv_alu_decode u_alu_decode (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (instr[31:25]),
    .alu_op  (dec_op),
    .illegal (dec_illegal)
  );

  // Last allowed unacknowledged cycle of a memory request
  assign wait_expired = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      cause_q  <= TRAP_NONE;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      cause_q  <= cause_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_nxt     = '0;
    cause_nxt    = cause_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    alu_src_a    = SRC_A_PC;
    alu_src_b    = SRC_B_RS2;
    imm_sel      = IMM_I;
    alu_op       = ALU_ADD;
    reg_we       = 1'b0;
    wb_sel       = WB_ALUOUT;
    retire       = 1'b0;
    halted       = 1'b0;

    case (state)
      S_IDLE: state_nxt = S_FETCH;

      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          state_nxt = S_DECODE;
        end else if (wait_expired) begin
          state_nxt = S_TRAP;
          cause_nxt = TRAP_MEM_TIMEOUT;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end

      // Branch/JAL target is computed speculatively into ALUOut
      S_DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        imm_sel   = (opcode == OPC_JAL) ? IMM_J : IMM_B;
        if (dec_illegal) begin
          state_nxt = S_TRAP;
          cause_nxt = TRAP_ILLEGAL;
        end else begin
          case (opcode)
            OPC_OP:              state_nxt = S_EXEC_R;
            OPC_OP_IMM:          state_nxt = S_EXEC_I;
            OPC_LOAD, OPC_STORE: state_nxt = S_MEM_ADDR;
            OPC_BRANCH:          state_nxt = S_BRANCH;
            OPC_JAL:             state_nxt = S_JAL;
            OPC_LUI:             state_nxt = S_LUI;
            default: begin
              state_nxt = S_TRAP;
              cause_nxt = TRAP_ILLEGAL;
            end
          endcase
        end
      end

      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = dec_op;
        state_nxt = S_WB_ALU;
      end

      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        imm_sel   = IMM_I;
        alu_op    = dec_op;
        state_nxt = S_WB_ALU;
      end

      S_WB_ALU: begin
        reg_we    = 1'b1;
        wb_sel    = WB_ALUOUT;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        imm_sel   = (opcode == OPC_STORE) ? IMM_S : IMM_I;
        state_nxt = (opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD, S_MEM_WR: begin
        mem_req      = 1'b1;
        mem_we       = (state == S_MEM_WR);
        mem_addr_sel = 1'b1;
        if (mem_ready) begin
          retire    = (state == S_MEM_WR);
          state_nxt = (state == S_MEM_WR) ? S_FETCH : S_WB_MEM;
        end else if (wait_expired) begin
          state_nxt = S_TRAP;
          cause_nxt = TRAP_MEM_TIMEOUT;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end

      S_WB_MEM: begin
        reg_we    = 1'b1;
        wb_sel    = WB_MDR;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_SUB;
        pc_we     = (funct3 == F3_BEQ) ? zero : !zero;
        pc_src    = pc_we;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end

      // PC already holds the link value; jump target sits in ALUOut
      S_JAL: begin
        reg_we    = 1'b1;
        wb_sel    = WB_PC;
        pc_we     = 1'b1;
        pc_src    = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end

      S_LUI: begin
        reg_we    = 1'b1;
        wb_sel    = WB_IMM;
        imm_sel   = IMM_U;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end

      S_TRAP: halted = 1'b1;

      default: state_nxt = S_IDLE;
    endcase
  end

  assign alu_ctrl   = ALU_CTRL_W'(alu_op);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Bench for riscv_mc_ctrl: directed instruction table, hand-written reset and
// timeout sequences, and random instructions checked against a phase-level model.
module tb_riscv_mc_ctrl;

  localparam int MW = 4;

  logic        clk, rst, zero, mem_ready;
  logic [31:0] instr;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src;
  logic [1:0]  alu_src_a, alu_src_b, wb_sel, trap_cause;
  logic [2:0]  imm_sel, alu_ctrl;
  logic        reg_we, retire, halted;

  riscv_mc_ctrl #(.ALU_CTRL_W(3), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_sel(imm_sel), .alu_ctrl(alu_ctrl),
    .reg_we(reg_we), .wb_sel(wb_sel), .retire(retire), .halted(halted),
    .trap_cause(trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src;
    logic [1:0] src_a, src_b;
    logic [2:0] imm_sel, alu;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       retire, halted;
    logic [1:0] cause;
  } outs_t;

  typedef struct {
    logic  ready;
    logic  zero;
    outs_t exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic        z;
    int          fw;
    int          mw;
    int          cyc;
  } dir_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic void push(input logic r, input logic z, input outs_t o);
    vec_t v;
    v.ready = r; v.zero = z; v.exp = o;
    vq.push_back(v);
  endfunction

  function automatic outs_t actual();
    outs_t a;
    a.mem_req = mem_req; a.mem_we = mem_we; a.addr_sel = mem_addr_sel;
    a.ir_we = ir_we; a.pc_we = pc_we; a.pc_src = pc_src;
    a.src_a = alu_src_a; a.src_b = alu_src_b; a.imm_sel = imm_sel;
    a.alu = alu_ctrl; a.reg_we = reg_we; a.wb_sel = wb_sel;
    a.retire = retire; a.halted = halted; a.cause = trap_cause;
    return a;
  endfunction

  // Which encodings the core implements
  function automatic bit legal(input logic [31:0] ins);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    case (opc)
      7'h33: return (f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6 || f3 == 3'd2))
                    || (f7 == 7'h20 && f3 == 3'd0);
      7'h13: return (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6 || f3 == 3'd2);
      7'h03, 7'h23: return (f3 == 3'd2);
      7'h63: return (f3 == 3'd0 || f3 == 3'd1);
      7'h6F, 7'h37: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [31:0] ins);
    case (ins[14:12])
      3'd0: return (ins[6:0] == 7'h33 && ins[31:25] == 7'h20) ? 3'd1 : 3'd0;
      3'd7: return 3'd3;
      3'd6: return 3'd2;
      3'd2: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic void trap_tail(input logic [1:0] cause);
    outs_t o;
    o = '0; o.halted = 1'b1; o.cause = cause;
    for (int i = 0; i < 3; i++) push(rb(), rb(), o);
  endfunction

  // A memory handshake that waits `waits` cycles, timing out at MW
  task automatic mem_phase(input outs_t wait_o, input outs_t done_o, input int waits,
                           output bit trapped);
    trapped = 1'b0;
    for (int i = 0; i < waits && i < MW; i++) push(1'b0, rb(), wait_o);
    if (waits >= MW) begin
      trap_tail(2'd2);
      trapped = 1'b1;
    end else begin
      push(1'b1, rb(), done_o);
    end
  endtask

  task automatic build(input logic [31:0] ins, input logic z, input int fw, input int mw,
                       output bit trapped);
    outs_t w, d, o;
    logic [6:0] opc;
    bit st, taken;
    opc = ins[6:0];
    w = '0; w.mem_req = 1'b1; w.src_b = 2'd1;
    d = w; d.ir_we = 1'b1; d.pc_we = 1'b1;
    mem_phase(w, d, fw, trapped);
    if (trapped) return;
    o = '0; o.src_a = 2'd1; o.src_b = 2'd2; o.imm_sel = (opc == 7'h6F) ? 3'd3 : 3'd2;
    push(rb(), rb(), o);
    if (!legal(ins)) begin
      trap_tail(2'd1);
      trapped = 1'b1;
      return;
    end
    o = '0;
    case (opc)
      7'h33, 7'h13: begin
        o.src_a = 2'd2; o.src_b = (opc == 7'h13) ? 2'd2 : 2'd0; o.alu = alu_of(ins);
        push(rb(), rb(), o);
        o = '0; o.reg_we = 1'b1; o.retire = 1'b1;
        push(rb(), rb(), o);
      end
      7'h03, 7'h23: begin
        st = (opc == 7'h23);
        o.src_a = 2'd2; o.src_b = 2'd2; o.imm_sel = st ? 3'd1 : 3'd0;
        push(rb(), rb(), o);
        w = '0; w.mem_req = 1'b1; w.mem_we = st; w.addr_sel = 1'b1;
        d = w; d.retire = st;
        mem_phase(w, d, mw, trapped);
        if (!trapped && !st) begin
          o = '0; o.reg_we = 1'b1; o.wb_sel = 2'd1; o.retire = 1'b1;
          push(rb(), rb(), o);
        end
      end
      7'h63: begin
        taken = (ins[14:12] == 3'd0) ? z : !z;
        o.src_a = 2'd2; o.alu = 3'd1; o.pc_we = taken; o.pc_src = taken; o.retire = 1'b1;
        push(rb(), z, o);
      end
      7'h6F: begin
        o.reg_we = 1'b1; o.wb_sel = 2'd2; o.pc_we = 1'b1; o.pc_src = 1'b1; o.retire = 1'b1;
        push(rb(), rb(), o);
      end
      7'h37: begin
        o.reg_we = 1'b1; o.wb_sel = 2'd3; o.imm_sel = 3'd4; o.retire = 1'b1;
        push(rb(), rb(), o);
      end
      default: ;
    endcase
  endtask

  // Apply up to n queued vectors (n < 0: all); returns cycle of first retire
  task automatic play(input string name, input int n, output int retire_at);
    vec_t  v;
    outs_t a;
    int    idx;
    idx = 0;
    retire_at = 0;
    while (vq.size() > 0 && (n < 0 || idx < n)) begin
      v = vq.pop_front();
      mem_ready = v.ready;
      zero = v.zero;
      @(negedge clk);
      a = actual();
      n_tests++;
      if (a !== v.exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: outputs got %h expected %h", name, idx + 1, a, v.exp);
      end
      if (a.retire === 1'b1 && retire_at == 0) retire_at = idx + 1;
      @(posedge clk);
      #1;
      idx++;
    end
  endtask

  task automatic do_reset(input string name);
    int r;
    rst = 1'b1;
    mem_ready = rb();
    @(posedge clk);
    #1;
    rst = 1'b0;
    vq.delete();
    push(rb(), rb(), '0);
    play(name, -1, r);
  endtask

  task automatic run_case(input string name, input logic [31:0] ins, input logic z,
                          input int fw, input int mw, input int exp_cyc);
    bit tr;
    int r;
    instr = ins;
    vq.delete();
    build(ins, z, fw, mw, tr);
    play(name, -1, r);
    if (exp_cyc >= 0) begin
      n_tests++;
      if (r != exp_cyc) begin
        n_fail++;
        $display("FAIL %s retire_cycle: got %0d expected %0d", name, r, exp_cyc);
      end
    end
    if (tr) do_reset({name, "_rst"});
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opc, f7;
    logic [2:0] f3;
    int r;
    case ($urandom_range(0, 9))
      0: opc = 7'h33;
      1: opc = 7'h13;
      2: opc = 7'h03;
      3: opc = 7'h23;
      4: opc = 7'h63;
      5: opc = 7'h6F;
      6: opc = 7'h37;
      7: opc = 7'h17;
      8: opc = 7'h67;
      default: opc = 7'($urandom);
    endcase
    f3 = 3'($urandom);
    r = $urandom_range(0, 3);
    f7 = (r == 0) ? 7'h20 : (r == 1) ? 7'($urandom) : 7'h00;
    return {f7, 10'($urandom), f3, 5'($urandom), opc};
  endfunction

  dir_t dt[12];

  initial begin
    int   r;
    bit   tr;
    int   fw, mw;

    dt[0]  = '{"add",        32'h002081B3, 1'b0, 0, 0, 4};
    dt[1]  = '{"lw_wait3",   32'h0040A283, 1'b0, 0, 3, 8};
    dt[2]  = '{"beq_taken",  32'h00208463, 1'b1, 0, 0, 3};
    dt[3]  = '{"beq_not",    32'h00208463, 1'b0, 0, 0, 3};
    dt[4]  = '{"sra_illegal",32'h4020D1B3, 1'b0, 0, 0, 0};
    dt[5]  = '{"sw",         32'h0020A423, 1'b0, 0, 0, 4};
    dt[6]  = '{"lui",        32'h123452B7, 1'b0, 0, 0, 3};
    dt[7]  = '{"jal",        32'h008000EF, 1'b0, 0, 0, 3};
    dt[8]  = '{"addi",       32'h00500093, 1'b1, 0, 0, 4};
    dt[9]  = '{"fetch_tmo",  32'h002081B3, 1'b0, 4, 0, 0};
    dt[10] = '{"fetch_last", 32'h002081B3, 1'b0, 3, 0, 7};
    dt[11] = '{"bne_taken",  32'h00209463, 1'b0, 0, 0, 3};

    rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; instr = '0;
    @(posedge clk);
    #1;
    do_reset("reset_idle");

    for (int i = 0; i < 12; i++)
      run_case(dt[i].name, dt[i].ins, dt[i].z, dt[i].fw, dt[i].mw, dt[i].cyc);

    // Reset while a store is waiting on memory
    instr = 32'h0020A423;
    vq.delete();
    build(32'h0020A423, 1'b0, 0, 3, tr);
    play("sw_mid", 4, r);
    vq.delete();
    do_reset("idle_after_mid_rst");
    run_case("add_after_rst", 32'h002081B3, 1'b0, 0, 0, 4);

    // Load timing out in MEM_RD, then ready arriving on the last allowed cycle
    run_case("lw_tmo", 32'h0040A283, 1'b0, 1, MW, 0);
    run_case("lw_last", 32'h0040A283, 1'b0, 0, MW - 1, 5 + MW - 1);

    for (int k = 0; k < 250; k++) begin
      fw = ($urandom_range(0, 19) == 0) ? MW + $urandom_range(0, 1) : $urandom_range(0, MW - 1);
      mw = ($urandom_range(0, 19) == 0) ? MW : $urandom_range(0, MW - 1);
      run_case("rand", rand_instr(), rb(), fw, mw, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
